// File: rtl/neural_layer_seq.sv
// Sequential layer evaluator: latches one Q8.8 input pair, then evaluates
// NEURONS two-weight step neurons one per clock against a local weight table
// and presents the packed activation vector until the consumer takes it.
module neural_layer_seq #(
    parameter int NEURONS = 4,
    parameter int ADDR_W  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                W_EN,
    input  logic [ADDR_W-1:0]   W_ADDR,
    input  logic [15:0]         W_CA,
    input  logic [15:0]         W_CB,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [15:0]         IN_A,
    input  logic [15:0]         IN_B,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [NEURONS-1:0]  OUT_F,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NEURONS - 1);

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic signed [15:0]        a_q, a_d;
    logic signed [15:0]        b_q, b_d;
    logic [NEURONS-1:0]        f_q, f_d;
    logic signed [15:0]        ca_q [NEURONS];
    logic signed [15:0]        ca_d [NEURONS];
    logic signed [15:0]        cb_q [NEURONS];
    logic signed [15:0]        cb_d [NEURONS];

    logic signed [15:0]        ca_sel, cb_sel;
    logic signed [31:0]        prod_a, prod_b;
    logic signed [32:0]        sum;
    logic                      f_bit;
    logic                      wr_ok;

    // Neuron datapath: full-precision Q16.16 products, 33-bit sum, strict > 0 step
    always_comb begin
        ca_sel = ca_q[idx_q];
        cb_sel = cb_q[idx_q];
        prod_a = 32'(a_q) * 32'(ca_sel);
        prod_b = 32'(b_q) * 32'(cb_sel);
        sum    = 33'(prod_a) + 33'(prod_b);
        f_bit  = !sum[32] && (sum != '0);
    end

    // Next-state, weight table update and progressive activation writes
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        wr_ok   = W_EN && (32'(W_ADDR) < NEURONS);
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    ca_d[W_ADDR] = W_CA;
                    cb_d[W_ADDR] = W_CB;
                end
                if (IN_VALID) begin
                    a_d     = IN_A;
                    b_d     = IN_B;
                    idx_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                f_d[idx_q] = f_bit;
                if (idx_q == LAST_IDX) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset clearing the table and result
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            for (int unsigned i = 0; i < NEURONS; i++) begin
                ca_q[i] <= '0;
                cb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            for (int unsigned i = 0; i < NEURONS; i++) begin
                ca_q[i] <= ca_d[i];
                cb_q[i] <= cb_d[i];
            end
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == HOLD);
    assign BUSY      = (state_q != IDLE);
    assign OUT_F     = f_q;

endmodule

// File: doc/neural_layer_seq.md
Name: neural_layer_seq

Overview:
- Sequential layer evaluator that sits directly downstream of the 2-input Q8.8 neuron calculation.
- Accepts one input pair (A, B) per transaction over a valid/ready handshake.
- Evaluates NEURONS two-weight step neurons one per clock, against a locally stored weight table.
- Presents the packed 1-bit activations as one output vector to the next layer.

Parameters:
NEURONS, 4, number of neurons in the layer (>=2)
ADDR_W, 2, weight-table index width; 2**ADDR_W >= NEURONS

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
W_EN  in  1  weight write strobe
W_ADDR  in  ADDR_W  neuron index for write
W_CA  in  16  signed Q8.8 coefficient for input A
W_CB  in  16  signed Q8.8 coefficient for input B
IN_VALID  in  1  input pair valid
IN_READY  out  1  block can accept input pair
IN_A  in  16  signed Q8.8 input A
IN_B  in  16  signed Q8.8 input B
OUT_VALID  out  1  OUT_F holds a complete result
OUT_READY  in  1  consumer accepts result
OUT_F  out  NEURONS  activation vector, bit i = neuron i
BUSY  out  1  high in EVAL or HOLD

Behaviour:
- Reset: applied when RST=1 at a clock edge; overrides all other inputs.
  - State -> IDLE; index counter=0.
  - All weight entries -> 0x0000.
  - OUT_F=0, OUT_VALID=0, IN_READY=1 after the edge, BUSY=0.
  - Reset mid-EVAL or mid-HOLD aborts the transaction; no partial result is ever flagged valid.
- Weight write: on an edge with W_EN=1 and state IDLE, table[W_ADDR] <= {W_CA, W_CB}.
  - Ignored when BUSY=1.
  - Ignored when W_ADDR >= NEURONS.
  - A write on the same edge as input acceptance still lands, since state is IDLE at that edge; it is visible to that evaluation.
- Neuron arithmetic:
  - p = IN_A*cA + IN_B*cB.
  - Each product is a full 16x16 signed multiply giving 32-bit Q16.16.
  - The sum is 33-bit signed. No truncation, no saturation.
  - f = 1 iff sum > 0 (strictly positive); sum == 0 gives f = 0.
- FSM IDLE / EVAL / HOLD:
  - IN_READY = (state==IDLE). OUT_VALID = (state==HOLD).
  - IDLE: on an edge with IN_VALID=1, latch IN_A/IN_B into internal regs, set idx=0, go to EVAL. Otherwise stay.
  - EVAL: each edge computes f for neuron idx from the latched A/B and table[idx], and writes it to OUT_F[idx].
    - If idx==NEURONS-1, go to HOLD; otherwise idx++.
    - Input handshake is not accepted in EVAL.
  - HOLD: OUT_F stable. On an edge with OUT_READY=1, go to IDLE. Otherwise stay indefinitely.
- OUT_F bits are overwritten progressively during EVAL. Consumers sample OUT_F only while OUT_VALID=1.
- Latency:
  - Accept edge k; OUT_VALID rises after edge k+NEURONS.
  - Result consumed at edge m; IN_READY high after edge m.
  - Next input can be accepted at edge m+1, giving a throughput of one transaction per NEURONS+2 cycles minimum.
- IN_A/IN_B changes after acceptance have no effect on the current transaction.

Test Plan:
- Weight load and basic eval:
  - Load n0=(0x0100,0x0100), n1=(0x0100,0xFF00), n2=(0xFF00,0xFF00), n3=(0x0000,0x0000).
  - Send A=0x0100, B=0x0100 -> OUT_VALID exactly 4 cycles after accept, OUT_F=4'b0001.
- Sign and zero boundary: same weights, A=0x0F01, B=0x0F00 -> OUT_F=4'b0011. Then A=0x0F00, B=0x0F01 -> OUT_F=4'b0001. Then A=0x0000, B=0x0000 -> OUT_F=4'b0000 (sum==0 gives 0).
- Width/overflow:
  - n0=(0x7FFF,0x7FFF), A=B=0x7FFF -> bit0=1 (no wrap).
  - n0=(0x7FFF,0x7FFF), A=B=0x8000 -> bit0=0.
  - n0=(0x8000,0x8000), A=B=0x8000 -> bit0=1.
- Backpressure: hold OUT_READY=0 for 5 cycles in HOLD -> OUT_VALID=1, IN_READY=0, OUT_F unchanged throughout. Assert OUT_READY -> IN_READY=1 next cycle.
- Busy write protection: pulse W_EN to n0 with (0xFF00,0xFF00) during EVAL -> ignored, next result unchanged. Repeat in IDLE -> takes effect on the following evaluation.
- Reset mid-operation: assert RST on the 2nd EVAL cycle -> after the edge OUT_VALID=0, IN_READY=1, OUT_F=0. A new eval with A=B=0x0100 -> OUT_F=4'b0000, since all weights are cleared.
